// File: rtl/cacheline_burst_adaptor_pkg.sv
//------------------------------------------------------------------------------
// Module   : cache_mux_types (package)
// Purpose  : Shared constants and FSM state encoding for the cache-line to
//            memory-burst adaptor.
// Contents : LINE_W - cache line width in bits
//            BEAT_W - memory burst beat width in bits
//            NBEAT  - beats per cache line
//            cla_state_t - adaptor FSM states
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cache_mux_types;

    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int NBEAT  = LINE_W / BEAT_W;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_BURST = 3'd1,
        WR_BURST = 3'd2,
        DONE     = 3'd3,
        TURN     = 3'd4
    } cla_state_t;

endpackage

`default_nettype wire

// File: rtl/cacheline_burst_adaptor.sv
//------------------------------------------------------------------------------
// Module   : cacheline_burst_adaptor
// Purpose  : Converts a cache line fill / writeback request into a fixed
//            4-beat memory burst, assembling or slicing the line beat by beat.
// Macro    : CLA_WRITEBACK_EN - when defined, the writeback (WR_BURST) path is
//            built; otherwise the block is read-only, line_write is ignored
//            and burst_write / burst_wdata are tied to 0.
// Ports    : clk          - clock, rising edge
//            rst          - asynchronous reset, active low
//            line_read    - line fill request, held until line_resp
//            line_write   - line writeback request, held until line_resp
//            line_addr    - line address (low 5 bits ignored)
//            line_wdata   - writeback line
//            line_rdata   - filled line, stable until next fill
//            line_resp    - one-cycle completion pulse
//            burst_read   - memory read burst request
//            burst_write  - memory write burst request
//            burst_addr   - burst base address
//            burst_wdata  - current write beat
//            burst_rdata  - current read beat
//            burst_resp   - one beat transferred this cycle
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cacheline_burst_adaptor #(
    parameter int LINE_W = cache_mux_types::LINE_W,
    parameter int BEAT_W = cache_mux_types::BEAT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_read,
    input  logic              line_write,
    input  logic [31:0]       line_addr,
    input  logic [LINE_W-1:0] line_wdata,
    output logic [LINE_W-1:0] line_rdata,
    output logic              line_resp,
    output logic              burst_read,
    output logic              burst_write,
    output logic [31:0]       burst_addr,
    output logic [BEAT_W-1:0] burst_wdata,
    input  logic [BEAT_W-1:0] burst_rdata,
    input  logic              burst_resp
);

    import cache_mux_types::*;

    localparam logic [1:0] C_LAST_BEAT = 2'(NBEAT - 1);

    cla_state_t        r_state;
    cla_state_t        w_next;
    logic [1:0]        r_beat;
    logic [31:0]       r_addr;
    logic [LINE_W-1:0] r_line;
    logic              w_write_req;
    logic              w_start;
    logic              w_in_burst;
    logic              w_beat;
    logic              w_last_beat;

`ifdef CLA_WRITEBACK_EN
    logic [LINE_W-1:0] r_wdata;

    assign w_write_req = line_write;
    assign burst_wdata = r_wdata[BEAT_W*int'(r_beat) +: BEAT_W];
`else
    // Writeback inputs have no function in the read-only build.
    logic w_unused_wb;

    assign w_write_req = 1'b0;
    assign burst_wdata = '0;
    assign w_unused_wb = ^{line_write, line_wdata};
`endif

    assign w_start     = (r_state == IDLE) && (line_read || w_write_req);
    assign w_in_burst  = (r_state == RD_BURST) || (r_state == WR_BURST);
    // burst_resp only counts while a burst is actually outstanding.
    assign w_beat      = burst_resp && w_in_burst;
    assign w_last_beat = w_beat && (r_beat == C_LAST_BEAT);

    assign burst_addr  = r_addr;
    assign line_rdata  = r_line;

    // State register, beat counter, request latches and line assembly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_beat  <= 2'd0;
            r_addr  <= 32'd0;
            r_line  <= '0;
`ifdef CLA_WRITEBACK_EN
            r_wdata <= '0;
`endif
        end else begin
            r_state <= w_next;
            if (w_start) begin
                // Bursts are line aligned: 32-byte boundary.
                r_addr  <= {line_addr[31:5], 5'd0};
`ifdef CLA_WRITEBACK_EN
                r_wdata <= line_wdata;
`endif
            end
            if (w_beat) begin
                r_beat <= r_beat + 2'd1;
            end
            if (w_beat && (r_state == RD_BURST)) begin
                r_line[BEAT_W*int'(r_beat) +: BEAT_W] <= burst_rdata;
            end
        end
    end

    // Next state and outputs.
    always_comb begin
        w_next      = r_state;
        burst_read  = 1'b0;
        burst_write = 1'b0;
        line_resp   = 1'b0;
        case (r_state)
            IDLE: begin
                // Read has priority over writeback.
                if (line_read) begin
                    w_next = RD_BURST;
                end else if (w_write_req) begin
                    w_next = WR_BURST;
                end
            end
            RD_BURST: begin
                burst_read = 1'b1;
                if (w_last_beat) begin
                    w_next = DONE;
                end
            end
`ifdef CLA_WRITEBACK_EN
            WR_BURST: begin
                burst_write = 1'b1;
                if (w_last_beat) begin
                    w_next = DONE;
                end
            end
`endif
            DONE: begin
                line_resp = 1'b1;
                w_next    = TURN;
            end
            // TURN absorbs a request the requester is still holding the
            // cycle after line_resp.
            TURN: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_cacheline_burst_adaptor.sv
`default_nettype none

module tb_cacheline_burst_adaptor;

    logic         clk;
    logic         rst;
    logic         line_read;
    logic         line_write;
    logic [31:0]  line_addr;
    logic [255:0] line_wdata;
    logic [255:0] line_rdata;
    logic         line_resp;
    logic         burst_read;
    logic         burst_write;
    logic [31:0]  burst_addr;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata;
    logic         burst_resp;

    int n_tests = 0;
    int n_fail  = 0;

    cacheline_burst_adaptor dut (
        .clk         (clk),
        .rst         (rst),
        .line_read   (line_read),
        .line_write  (line_write),
        .line_addr   (line_addr),
        .line_wdata  (line_wdata),
        .line_rdata  (line_rdata),
        .line_resp   (line_resp),
        .burst_read  (burst_read),
        .burst_write (burst_write),
        .burst_addr  (burst_addr),
        .burst_wdata (burst_wdata),
        .burst_rdata (burst_rdata),
        .burst_resp  (burst_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]       addr;
        logic [31:0]       exp_addr;
        logic [3:0][63:0]  beats;
        int                gap;
        bit                drop;
        logic [255:0]      exp_line;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts in IDLE (1 ns after an edge); returns in IDLE.
    task automatic do_read(input logic [31:0] addr, input logic [3:0][63:0] beats,
                           input int gap, input logic [31:0] exp_addr,
                           input logic [255:0] exp_line, input bit drop, input bit hold);
        line_read = 1'b1;
        line_addr = addr;
        step();
        line_addr = ~addr;
        for (int i = 0; i < 4; i++) begin
            for (int w = 0; w < gap; w++) begin
                chk("rd_wait_burst_read", 256'(burst_read), 256'd1);
                chk("rd_wait_line_resp", 256'(line_resp), 256'd0);
                step();
            end
            chk("rd_burst_read", 256'(burst_read), 256'd1);
            chk("rd_burst_write", 256'(burst_write), 256'd0);
            chk("rd_burst_addr", 256'(burst_addr), 256'(exp_addr));
            chk("rd_line_resp_early", 256'(line_resp), 256'd0);
            burst_resp  = 1'b1;
            burst_rdata = beats[i];
            step();
            burst_resp  = 1'b0;
            burst_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
            if (drop && i == 0) line_read = 1'b0;
        end
        chk("done_line_resp", 256'(line_resp), 256'd1);
        chk("done_burst_read", 256'(burst_read), 256'd0);
        chk("done_line_rdata", line_rdata, exp_line);
        if (!hold) line_read = 1'b0;
        // Stray responses outside a burst must be ignored.
        burst_resp = 1'b1;
        step();
        chk("turn_line_resp", 256'(line_resp), 256'd0);
        chk("turn_burst_read", 256'(burst_read), 256'd0);
        chk("turn_burst_write", 256'(burst_write), 256'd0);
        chk("turn_line_rdata", line_rdata, exp_line);
        step();
        burst_resp = 1'b0;
        chk("idle_burst_read", 256'(burst_read), 256'd0);
        chk("idle_line_resp", 256'(line_resp), 256'd0);
        chk("idle_line_rdata", line_rdata, exp_line);
    endtask

`ifdef CLA_WRITEBACK_EN
    task automatic do_write(input logic [31:0] addr, input logic [255:0] wdata,
                            input logic [31:0] exp_addr, input logic [3:0][63:0] exp_beats);
        line_write = 1'b1;
        line_addr  = addr;
        line_wdata = wdata;
        step();
        line_wdata = ~wdata;
        for (int i = 0; i < 4; i++) begin
            chk("wr_burst_write", 256'(burst_write), 256'd1);
            chk("wr_burst_read", 256'(burst_read), 256'd0);
            chk("wr_burst_addr", 256'(burst_addr), 256'(exp_addr));
            chk("wr_burst_wdata", 256'(burst_wdata), 256'(exp_beats[i]));
            chk("wr_line_resp_early", 256'(line_resp), 256'd0);
            burst_resp = 1'b1;
            step();
            burst_resp = 1'b0;
        end
        chk("wr_done_line_resp", 256'(line_resp), 256'd1);
        chk("wr_done_burst_write", 256'(burst_write), 256'd0);
        line_write = 1'b0;
        step();
        chk("wr_turn_line_resp", 256'(line_resp), 256'd0);
        step();
        chk("wr_idle_burst_write", 256'(burst_write), 256'd0);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0].addr     = 32'h0000_1234;
        vecs[0].exp_addr = 32'h0000_1220;
        vecs[0].beats    = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        vecs[0].gap      = 0;
        vecs[0].drop     = 1'b0;
        vecs[0].exp_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};

        vecs[1].addr     = 32'h8000_001F;
        vecs[1].exp_addr = 32'h8000_0000;
        vecs[1].beats    = {64'h0F0F_0F0F_0F0F_0F0F, 64'hFEDC_BA98_7654_3210,
                            64'h0123_4567_89AB_CDEF, 64'hA5A5_A5A5_A5A5_A5A5};
        vecs[1].gap      = 2;
        vecs[1].drop     = 1'b0;
        vecs[1].exp_line = {64'h0F0F_0F0F_0F0F_0F0F, 64'hFEDC_BA98_7654_3210,
                            64'h0123_4567_89AB_CDEF, 64'hA5A5_A5A5_A5A5_A5A5};

        vecs[2].addr     = 32'hFFFF_FFFF;
        vecs[2].exp_addr = 32'hFFFF_FFE0;
        vecs[2].beats    = {64'h8000_0000_0000_0001, 64'h0000_0000_0000_0000,
                            64'hFFFF_FFFF_FFFF_FFFF, 64'h5555_AAAA_5555_AAAA};
        vecs[2].gap      = 1;
        vecs[2].drop     = 1'b1;
        vecs[2].exp_line = {64'h8000_0000_0000_0001, 64'h0000_0000_0000_0000,
                            64'hFFFF_FFFF_FFFF_FFFF, 64'h5555_AAAA_5555_AAAA};

        vecs[3].addr     = 32'h0000_0020;
        vecs[3].exp_addr = 32'h0000_0020;
        vecs[3].beats    = {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003,
                            64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001};
        vecs[3].gap      = 0;
        vecs[3].drop     = 1'b0;
        vecs[3].exp_line = {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003,
                            64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001};

        rst         = 1'b0;
        line_read   = 1'b0;
        line_write  = 1'b0;
        line_addr   = 32'h0000_1234;
        line_wdata  = {4{64'h1357_9BDF_2468_ACE0}};
        burst_rdata = 64'h0;
        burst_resp  = 1'b0;

        #12;
        chk("rst_line_rdata", line_rdata, 256'd0);
        chk("rst_line_resp", 256'(line_resp), 256'd0);
        chk("rst_burst_read", 256'(burst_read), 256'd0);
        chk("rst_burst_write", 256'(burst_write), 256'd0);
        chk("rst_burst_addr", 256'(burst_addr), 256'd0);
        chk("rst_burst_wdata", 256'(burst_wdata), 256'd0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Table-driven reads: zero-wait, gapped, boundary addresses, mid-burst drop.
        for (int v = 0; v < 4; v++) begin
            do_read(vecs[v].addr, vecs[v].beats, vecs[v].gap, vecs[v].exp_addr,
                    vecs[v].exp_line, vecs[v].drop, 1'b0);
        end

        // Request held past line_resp: DONE/TURN must not re-issue; next burst from IDLE.
        do_read(vecs[0].addr, vecs[0].beats, 0, vecs[0].exp_addr, vecs[0].exp_line, 1'b0, 1'b1);
        do_read(vecs[3].addr, vecs[3].beats, 1, vecs[3].exp_addr, vecs[3].exp_line, 1'b0, 1'b0);

        // Reset after beat 2 of a read.
        line_read = 1'b1;
        line_addr = 32'h4000_0047;
        step();
        burst_resp  = 1'b1;
        burst_rdata = 64'h9999_9999_9999_9999;
        step();
        burst_rdata = 64'h8888_8888_8888_8888;
        step();
        burst_resp = 1'b0;
        chk("pre_rst_burst_read", 256'(burst_read), 256'd1);
        chk("pre_rst_burst_addr", 256'(burst_addr), 256'h4000_0040);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_burst_read", 256'(burst_read), 256'd0);
        chk("mid_rst_line_resp", 256'(line_resp), 256'd0);
        chk("mid_rst_line_rdata", line_rdata, 256'd0);
        chk("mid_rst_burst_addr", 256'(burst_addr), 256'd0);
        line_read = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
        for (int c = 0; c < 4; c++) begin
            chk("post_rst_line_resp", 256'(line_resp), 256'd0);
            chk("post_rst_burst_read", 256'(burst_read), 256'd0);
            step();
        end
        do_read(vecs[1].addr, vecs[1].beats, 0, vecs[1].exp_addr, vecs[1].exp_line, 1'b0, 1'b0);

`ifdef CLA_WRITEBACK_EN
        do_write(32'h0000_2345, {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                 32'h0000_2340,
                 {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                  64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA});
        // Read and write together: read first, write after TURN.
        line_write = 1'b1;
        line_wdata = {64'h4, 64'h3, 64'h2, 64'h1};
        do_read(vecs[0].addr, vecs[0].beats, 0, vecs[0].exp_addr, vecs[0].exp_line, 1'b0, 1'b0);
        do_write(32'h0000_0060, {64'h4, 64'h3, 64'h2, 64'h1}, 32'h0000_0060,
                 {64'h4, 64'h3, 64'h2, 64'h1});
`else
        // Read-only build: writeback requests are ignored.
        line_write = 1'b1;
        line_wdata = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                      64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        for (int c = 0; c < 4; c++) begin
            burst_resp = 1'b1;
            step();
            chk("ro_burst_write", 256'(burst_write), 256'd0);
            chk("ro_burst_wdata", 256'(burst_wdata), 256'd0);
            chk("ro_burst_read", 256'(burst_read), 256'd0);
            chk("ro_line_resp", 256'(line_resp), 256'd0);
        end
        burst_resp = 1'b0;
        // Read and write together: only the read is performed.
        do_read(vecs[0].addr, vecs[0].beats, 0, vecs[0].exp_addr, vecs[0].exp_line, 1'b0, 1'b0);
        step();
        chk("ro_after_burst_write", 256'(burst_write), 256'd0);
        chk("ro_after_line_resp", 256'(line_resp), 256'd0);
        line_write = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
